// File: rtl/cpmath_mux_pkg.sv
// Shared constants for the mux/arbiter register slice: mode encodings and
// default channel geometry.
package cpmath_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_N     = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: returns the first requesting index at or after
// ptr, wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // Scan from the farthest offset back to ptr so the closest hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(N);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel multiplexer/arbiter feeding a single registered output slot.
// Select mode picks channel sel; round-robin mode rotates from ptr.
// Optional feature: define MUX_ARB_REG_CNT_EN to add the xfer_cnt output,
// a 16-bit wrapping count of words popped downstream.
module mux_arb_reg
  import cpmath_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  parameter  int unsigned N     = DEFAULT_N,
  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               rr_mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
`ifdef MUX_ARB_REG_CNT_EN
  ,
  output logic [15:0]        xfer_cnt
`endif
);

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Slot is free to load when empty or being drained this cycle.
  assign load_en = ~out_valid_q | out_ready;

  // Grant selection; an out-of-range sel grants nothing.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    if (rr_mode == MODE_RR) begin
      grant_idx = rr_idx;
      grant_vld = rr_vld;
    end else begin
      grant_idx = sel;
      grant_vld = (int'(sel) < int'(N)) && in_valid[sel];
    end
  end

  // Reset blocks any acceptance so no word is consumed and then lost.
  assign xfer = load_en & grant_vld & ~reset;

  // Steer the granted channel's word and raise its ready bit.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = xfer;
      end
    end
  end

  // Pointer advances past the winner only on a round-robin transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && rr_mode == MODE_RR) begin
      ptr_d = (int'(grant_idx) == int'(N) - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load_en) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_data_q <= grant_data;
          out_src_q  <= grant_idx;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

`ifdef MUX_ARB_REG_CNT_EN
  logic [15:0] cnt_q;

  // Count downstream pops; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// Scoreboard bench for mux_arb_reg (N=4, WIDTH=32): directed scenarios then
// random traffic, checked against a queue-based reference model.
module tb_mux_arb_reg;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [1:0]     sel;
  logic           rr_mode;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_src;
`ifdef MUX_ARB_REG_CNT_EN
  logic [15:0]    xfer_cnt;
`endif

  mux_arb_reg #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef MUX_ARB_REG_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          known;
    logic [3:0]  ready;
    bit          valid;
    bit          hold;
    logic [31:0] data;
    logic [1:0]  src;
    logic [15:0] cnt;
  } cyc_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
  } word_t;

  cyc_t  cyc_q[$];
  word_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: slot occupancy, held word, rotation start.
  bit          m_known = 0;
  bit          m_valid = 0;
  logic [31:0] m_data  = '0;
  logic [1:0]  m_src   = '0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;

  // Monitor: checks per-cycle expectations and pops words on handshake.
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      cyc_t c;
      word_t e;
      c = cyc_q.pop_front();
      checks++;
      if (in_ready !== c.ready) begin
        errors++;
        $display("FAIL in_ready: got %b want %b at %0t", in_ready, c.ready, $time);
      end
      if (c.known) begin
        checks++;
        if (out_valid !== c.valid) begin
          errors++;
          $display("FAIL out_valid: got %b want %b at %0t", out_valid, c.valid, $time);
        end
        if (c.hold) begin
          checks++;
          if (out_data !== c.data || out_src !== c.src) begin
            errors++;
            $display("FAIL hold: got %h/%0d want %h/%0d at %0t",
                     out_data, out_src, c.data, c.src, $time);
          end
        end
`ifdef MUX_ARB_REG_CNT_EN
        checks++;
        if (xfer_cnt !== c.cnt) begin
          errors++;
          $display("FAIL xfer_cnt: got %0d want %0d at %0t", xfer_cnt, c.cnt, $time);
        end
`endif
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop: got %h/%0d want nothing at %0t", out_data, out_src, $time);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_src !== e.src) begin
            errors++;
            $display("FAIL word: got %h/%0d want %h/%0d at %0t",
                     out_data, out_src, e.data, e.src, $time);
          end
        end
      end
      // A word still held when reset hits is dropped.
      if (c.rst) exp_q.delete();
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cycle(input bit rst, input bit rr, input int s, input logic [3:0] v,
                       input bit ordy, input bit fix, input logic [31:0] fixw);
    cyc_t  c;
    word_t w;
    bit    load, gv, xf;
    int    g;
    logic [31:0] words [N];
    for (int i = 0; i < N; i++) words[i] = $urandom;
    if (fix) words[2] = fixw;
    reset     = rst;
    rr_mode   = rr;
    sel       = 2'(s);
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = words[i];

    load = !m_valid || ordy;
    gv   = 0;
    g    = 0;
    if (rr) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!gv && v[idx]) begin gv = 1; g = idx; end
      end
    end else if (s < N && v[s]) begin
      gv = 1; g = s;
    end
    xf = !rst && load && gv;

    c.rst   = rst;
    c.known = m_known;
    c.ready = xf ? 4'(1 << g) : 4'b0;
    c.valid = m_valid;
    c.hold  = m_valid && !ordy;
    c.data  = m_data;
    c.src   = m_src;
    c.cnt   = 16'(m_cnt);
    cyc_q.push_back(c);
    if (xf) begin
      w.data = words[g];
      w.src  = 2'(g);
      exp_q.push_back(w);
    end

    if (rst) begin
      m_known = 1; m_valid = 0; m_data = '0; m_src = '0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_valid && ordy) m_cnt = (m_cnt + 1) % 65536;
      if (load) begin
        m_valid = xf;
        if (xf) begin m_data = words[g]; m_src = 2'(g); end
      end
      if (rr && xf) m_ptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; rr_mode = 0; sel = 0; in_valid = 0; out_ready = 0; in_data = '0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 4'b0000, 1, 0, '0);
    cycle(1, 0, 0, 4'b1111, 1, 0, '0);
    // Select mode, channel 2 carries DEADBEEF.
    cycle(0, 0, 2, 4'b0100, 1, 1, 32'hDEADBEEF);
    cycle(0, 0, 0, 4'b0000, 1, 0, '0);
    // Round-robin over all valid: sources 0,1,2,3,0.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 4'b1111, 1, 0, '0);
    cycle(0, 1, 0, 4'b0000, 1, 0, '0);
    // Back-pressure with new inputs pending, then release.
    cycle(0, 1, 0, 4'b1111, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'b1111, 0, 0, '0);
    cycle(0, 1, 0, 4'b1111, 1, 0, '0);
    cycle(0, 1, 0, 4'b0000, 1, 0, '0);
    cycle(0, 1, 0, 4'b0000, 1, 0, '0);
    // Move ptr to 3, then only channels 0 and 1 request.
    cycle(0, 1, 0, 4'b0100, 1, 0, '0);
    cycle(0, 1, 0, 4'b0011, 1, 0, '0);
    cycle(0, 1, 0, 4'b0011, 1, 0, '0);
    // Reset with a word held and stalled; pointer must restart at 0.
    cycle(0, 1, 0, 4'b1000, 0, 0, '0);
    cycle(1, 1, 0, 4'b1111, 0, 0, '0);
    cycle(0, 1, 0, 4'b1111, 1, 0, '0);
    cycle(0, 1, 0, 4'b0000, 1, 0, '0);
    // Random traffic, with mode flips and occasional reset.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 3)),
            4'($urandom), ($urandom_range(0, 9) < 7), 0, '0);
    end
`ifdef MUX_ARB_REG_CNT_EN
    cycle(1, 1, 0, 4'b1111, 1, 0, '0);
    for (int i = 0; i < 65540; i++) cycle(0, 1, 0, 4'b1111, 1, 0, '0);
`endif
    cycle(0, 0, 0, 4'b0000, 1, 0, '0);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
MUX_ARB_REG -- requirements
Module: mux_arb_reg

Interface
REQ-001 Parameter WIDTH, default 32, bits per data channel.
REQ-002 Parameter N, default 4, number of input channels, legal range 2..16.
REQ-003 Localparam SEL_W = max(1, clog2(N)), select and source-index width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel data valid.
REQ-008 in_ready  output  N  per-channel accept; combinational.
REQ-009 sel  input  SEL_W  channel select, used in select mode.
REQ-010 rr_mode  input  1  0 = select mode, 1 = round-robin mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_src  output  SEL_W  registered index of the channel that supplied out_data.

Function
REQ-015 The output register SHALL load (load_en) when out_valid=0 or out_ready=1.
REQ-016 Select mode: grant = sel; a transfer SHALL occur when load_en and in_valid[sel]; sel>=N SHALL grant nothing.
REQ-017 Round-robin mode: grant SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ... mod N.
REQ-018 After each round-robin transfer, ptr SHALL become (grant+1) mod N; otherwise ptr SHALL hold.
REQ-019 in_ready[i] SHALL be 1 only when load_en=1 and i equals a valid grant; all other bits SHALL be 0.
REQ-020 On a transfer, out_data and out_src SHALL take the granted word and index at the next edge, and out_valid SHALL become 1: latency 1 cycle.
REQ-021 When load_en=1 and no transfer occurs, out_valid SHALL become 0.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL hold stable.
REQ-023 A pop and a load in the same cycle SHALL both take effect, sustaining 1 word per cycle.
REQ-024 A change of rr_mode SHALL take effect in the same cycle; ptr SHALL be retained across mode changes.
REQ-025 Select mode SHALL not modify ptr.

Reset
REQ-026 With reset=1 at an edge: out_valid=0, out_data=0, out_src=0, ptr=0.
REQ-027 During reset, in_ready SHALL be all 0.
REQ-028 A word held at reset assertion SHALL be discarded.

Configuration
REQ-029 Macro MUX_ARB_REG_CNT_EN defined: the block SHALL add output port xfer_cnt [15:0].
REQ-030 xfer_cnt SHALL increment on each out_valid & out_ready cycle, wrap 0xFFFF->0, and reset to 0.
REQ-031 Macro MUX_ARB_REG_CNT_EN undefined: the port and the counter SHALL be absent, with otherwise identical behaviour.

Structure
REQ-032 Shared package cpmath_mux_pkg SHALL hold the mode constants MODE_SEL=1'b0 and MODE_RR=1'b1 and the default WIDTH and N.
REQ-033 Sub-module rr_pick(N) SHALL implement the rotating priority search: inputs req[N] and ptr; outputs gnt_idx and gnt_vld.

Verification
REQ-034 N=4, rr_mode=0, sel=2, in_valid=4'b0100, in_data ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xDEADBEEF, out_src=2.
REQ-035 rr_mode=1, in_valid=4'b1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0, one word per cycle.
REQ-036 out_valid=1, out_ready=0 for 3 cycles with new inputs valid -> in_ready=0 and out_data unchanged; out_ready=1 -> pop, and the next word appears the following cycle.
REQ-037 rr_mode=1, ptr=3, in_valid=4'b0011 -> grant 0, then ptr=1, next grant 1.
REQ-038 Reset asserted with out_valid=1 -> next cycle out_valid=0 and ptr=0; with MUX_ARB_REG_CNT_EN defined, xfer_cnt=0, and after 65536 transfers xfer_cnt=0 again.
